// File: rtl/aip_responder_if.sv
// Host-side AIP bus bundle: select, data, strobes and the interrupt line.
// The host drives the master modport; aip_responder sits on the slave modport.
interface aip_responder_if #(
  parameter int DATA_WIDTH   = 32,
  parameter int CONFIG_WIDTH = 5
);
  logic [CONFIG_WIDTH-1:0] aip_config;
  logic [DATA_WIDTH-1:0]   aip_dataIn;
  logic [DATA_WIDTH-1:0]   aip_dataOut;
  logic                    aip_read;
  logic                    aip_write;
  logic                    aip_start;
  logic                    aip_int;

  modport master (
    output aip_config, aip_dataIn, aip_read, aip_write, aip_start,
    input  aip_dataOut, aip_int
  );

  modport slave (
    input  aip_config, aip_dataIn, aip_read, aip_write, aip_start,
    output aip_dataOut, aip_int
  );
endinterface

// File: rtl/aip_responder.sv
// Core-side AIP slave: strobe edge decode, auto-incrementing memory/config pointers,
// status/interrupt register and the start/busy handshake with the core.
module aip_responder #(
  parameter int                    DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] ID           = 32'h00001001,
  parameter int                    CONFIG_WIDTH = 5,
  parameter int                    MEM_IN_AW    = 8,
  parameter int                    MEM_OUT_AW   = 8,
  parameter int                    CONF_AW      = 3,
  parameter int                    NUM_INT      = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  aip_responder_if.slave                    bus,
  output logic                              mem_in_we,
  output logic [MEM_IN_AW-1:0]              mem_in_addr,
  output logic [DATA_WIDTH-1:0]             mem_in_data,
  output logic [MEM_OUT_AW-1:0]             mem_out_addr,
  input  logic [DATA_WIDTH-1:0]             mem_out_data,
  output logic [DATA_WIDTH*(2**CONF_AW)-1:0] conf_regs,
  output logic                              core_start,
  input  logic                              core_done,
  input  logic [NUM_INT-1:0]                int_set
);
  localparam int NUM_CONF = 2**CONF_AW;

  localparam logic [CONFIG_WIDTH-1:0] SEL_MEM_IN   = CONFIG_WIDTH'(0);
  localparam logic [CONFIG_WIDTH-1:0] SEL_PTR_IN   = CONFIG_WIDTH'(1);
  localparam logic [CONFIG_WIDTH-1:0] SEL_MEM_OUT  = CONFIG_WIDTH'(2);
  localparam logic [CONFIG_WIDTH-1:0] SEL_PTR_OUT  = CONFIG_WIDTH'(3);
  localparam logic [CONFIG_WIDTH-1:0] SEL_CONF     = CONFIG_WIDTH'(4);
  localparam logic [CONFIG_WIDTH-1:0] SEL_PTR_CONF = CONFIG_WIDTH'(5);
  localparam logic [CONFIG_WIDTH-1:0] SEL_STATUS   = CONFIG_WIDTH'(30);
  localparam logic [CONFIG_WIDTH-1:0] SEL_ID       = CONFIG_WIDTH'(31);

  typedef enum logic {ST_IDLE, ST_BUSY} state_t;

  state_t                  state_reg;
  logic                    read_prev_reg, write_prev_reg, start_prev_reg;
  logic                    rd_edge, wr_edge, st_edge;
  logic [MEM_IN_AW-1:0]    ptr_in_reg;
  logic [MEM_OUT_AW-1:0]   ptr_out_reg;
  logic [CONF_AW-1:0]      ptr_conf_reg;
  logic [NUM_INT-1:0]      flags_reg, mask_reg, flags_clr;
  logic [DATA_WIDTH-1:0]   status_word;

  assign rd_edge      = bus.aip_read  & ~read_prev_reg;
  assign wr_edge      = bus.aip_write & ~write_prev_reg;
  assign st_edge      = bus.aip_start & ~start_prev_reg;
  assign mem_out_addr = ptr_out_reg;

  always_comb begin
    status_word                = '0;
    status_word[NUM_INT-1:0]   = flags_reg;
    status_word[8]             = (state_reg == ST_BUSY);
    status_word[16 +: NUM_INT] = mask_reg;
  end

  always_comb begin
    flags_clr = '0;
    if (wr_edge && bus.aip_config == SEL_STATUS) flags_clr = bus.aip_dataIn[NUM_INT-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      read_prev_reg  <= 1'b0;
      write_prev_reg <= 1'b0;
      start_prev_reg <= 1'b0;
    end else begin
      read_prev_reg  <= bus.aip_read;
      write_prev_reg <= bus.aip_write;
      start_prev_reg <= bus.aip_start;
    end
  end

  // Write side: input-memory port, pointer loads and the interrupt mask.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_in_we    <= 1'b0;
      mem_in_addr  <= '0;
      mem_in_data  <= '0;
      ptr_in_reg   <= '0;
      ptr_conf_reg <= '0;
      mask_reg     <= '0;
    end else begin
      mem_in_we <= 1'b0;
      if (wr_edge) begin
        case (bus.aip_config)
          SEL_MEM_IN: begin
            mem_in_we   <= 1'b1;
            mem_in_addr <= ptr_in_reg;
            mem_in_data <= bus.aip_dataIn;
            ptr_in_reg  <= ptr_in_reg + 1'b1;
          end
          SEL_PTR_IN:   ptr_in_reg   <= bus.aip_dataIn[MEM_IN_AW-1:0];
          SEL_CONF:     ptr_conf_reg <= ptr_conf_reg + 1'b1;
          SEL_PTR_CONF: ptr_conf_reg <= bus.aip_dataIn[CONF_AW-1:0];
          SEL_STATUS:   mask_reg     <= bus.aip_dataIn[16 +: NUM_INT];
          default: ;
        endcase
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CONF; gi++) begin : g_conf
      logic [DATA_WIDTH-1:0] conf_reg;
      always_ff @(posedge clk or posedge rst) begin
        if (rst)
          conf_reg <= '0;
        else if (wr_edge && bus.aip_config == SEL_CONF && ptr_conf_reg == CONF_AW'(gi))
          conf_reg <= bus.aip_dataIn;
      end
      assign conf_regs[gi*DATA_WIDTH +: DATA_WIDTH] = conf_reg;
    end
  endgenerate

  // A write edge shadows a coincident read edge, so the read data simply holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.aip_dataOut <= '0;
      ptr_out_reg     <= '0;
    end else if (wr_edge) begin
      if (bus.aip_config == SEL_PTR_OUT) ptr_out_reg <= bus.aip_dataIn[MEM_OUT_AW-1:0];
    end else if (rd_edge) begin
      case (bus.aip_config)
        SEL_MEM_OUT: begin
          bus.aip_dataOut <= mem_out_data;
          ptr_out_reg     <= ptr_out_reg + 1'b1;
        end
        SEL_STATUS: bus.aip_dataOut <= status_word;
        SEL_ID:     bus.aip_dataOut <= ID;
        default:    bus.aip_dataOut <= '0;
      endcase
    end
  end

  // Set is OR-ed in after the clear so a same-cycle set survives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_reg   <= '0;
      bus.aip_int <= 1'b0;
    end else begin
      flags_reg   <= (flags_reg & ~flags_clr) | int_set;
      bus.aip_int <= |(flags_reg & mask_reg);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      core_start <= 1'b0;
    end else begin
      core_start <= 1'b0;
      case (state_reg)
        ST_IDLE: if (st_edge) begin
          core_start <= 1'b1;
          state_reg  <= ST_BUSY;
        end
        ST_BUSY: if (core_done) state_reg <= ST_IDLE;
        default: state_reg <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_aip_responder.sv
// Directed bench for aip_responder: transaction-level model plus per-cycle output compare
// and literal spot checks taken straight from the register map.
module tb_aip_responder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  aip_responder_if #(.DATA_WIDTH(32), .CONFIG_WIDTH(5)) bus ();

  logic         mem_in_we;
  logic [7:0]   mem_in_addr;
  logic [31:0]  mem_in_data;
  logic [7:0]   mem_out_addr;
  logic [31:0]  mem_out_data;
  logic [255:0] conf_regs;
  logic         core_start;
  logic         core_done = 1'b0;
  logic [7:0]   int_set   = 8'h00;

  aip_responder dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .mem_in_we    (mem_in_we),
    .mem_in_addr  (mem_in_addr),
    .mem_in_data  (mem_in_data),
    .mem_out_addr (mem_out_addr),
    .mem_out_data (mem_out_data),
    .conf_regs    (conf_regs),
    .core_start   (core_start),
    .core_done    (core_done),
    .int_set      (int_set)
  );

  // Output memory: synchronous read, one cycle latency.
  logic [31:0] ram [256];
  always @(posedge clk) mem_out_data <= ram[mem_out_addr];

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  // Model state
  int          m_ptr_in, m_ptr_out, m_ptr_conf;
  logic [31:0] m_conf [8];
  logic [7:0]  m_flags, m_mask;
  logic        m_busy;
  logic [31:0] exp_dout;
  logic        exp_we, exp_start, exp_int;
  logic [7:0]  exp_waddr;
  logic [31:0] exp_wdata;

  typedef struct { logic [7:0] a; logic [31:0] d; } wr_t;
  wr_t wlog[$];
  int  start_cnt = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] m_status();
    return {8'h00, m_mask, 7'h00, m_busy, m_flags};
  endfunction

  function automatic logic [255:0] m_conf_flat();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = m_conf[i];
    return v;
  endfunction

  task automatic model_reset();
    m_ptr_in = 0; m_ptr_out = 0; m_ptr_conf = 0;
    for (int i = 0; i < 8; i++) m_conf[i] = 32'h0;
    m_flags = 8'h00; m_mask = 8'h00; m_busy = 1'b0;
    exp_dout = 32'h0; exp_we = 1'b0; exp_start = 1'b0;
    exp_waddr = 8'h00; exp_wdata = 32'h0;
  endtask

  task automatic model_write(input int sel, input logic [31:0] d);
    case (sel)
      0: begin
        exp_we = 1'b1; exp_waddr = 8'(m_ptr_in); exp_wdata = d;
        m_ptr_in = (m_ptr_in + 1) % 256;
      end
      1: m_ptr_in   = int'(d[7:0]);
      3: m_ptr_out  = int'(d[7:0]);
      4: begin m_conf[m_ptr_conf] = d; m_ptr_conf = (m_ptr_conf + 1) % 8; end
      5: m_ptr_conf = int'(d[2:0]);
      30: begin m_flags = m_flags & ~d[7:0]; m_mask = d[23:16]; end
      default: ;
    endcase
  endtask

  task automatic model_read(input int sel);
    case (sel)
      2: begin exp_dout = ram[m_ptr_out]; m_ptr_out = (m_ptr_out + 1) % 256; end
      30: exp_dout = m_status();
      31: exp_dout = 32'h00001001;
      default: exp_dout = 32'h0;
    endcase
  endtask

  // Strobes are held two cycles to show only the rising edge counts.
  task automatic host_access(input bit do_rd, input bit do_wr, input int sel,
                             input logic [31:0] d, input logic [7:0] iset);
    @(negedge clk);
    bus.aip_config = 5'(sel); bus.aip_dataIn = d;
    bus.aip_read = do_rd; bus.aip_write = do_wr; int_set = iset;
    @(posedge clk); #1;
    if (do_wr) model_write(sel, d);
    else if (do_rd) model_read(sel);
    m_flags = m_flags | iset;
    $display("[TB] rd=%0d wr=%0d cfg=%0d data=%08h int_set=%02h", do_rd, do_wr, sel, d, iset);
    @(negedge clk); int_set = 8'h00;
    @(posedge clk); #1; exp_we = 1'b0;
    @(negedge clk); bus.aip_read = 1'b0; bus.aip_write = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic hw(input int sel, input logic [31:0] d);
    host_access(1'b0, 1'b1, sel, d, 8'h00);
  endtask

  task automatic hr(input int sel);
    host_access(1'b1, 1'b0, sel, 32'h0, 8'h00);
  endtask

  task automatic int_pulse(input logic [7:0] bits);
    @(negedge clk); int_set = bits;
    @(posedge clk); #1; m_flags = m_flags | bits;
    $display("[TB] int_set pulse %02h", bits);
    @(negedge clk); int_set = 8'h00;
    repeat (2) @(negedge clk);
  endtask

  task automatic host_start();
    @(negedge clk); bus.aip_start = 1'b1;
    @(posedge clk); #1;
    if (!m_busy) begin exp_start = 1'b1; m_busy = 1'b1; end
    $display("[TB] start strobe");
    @(posedge clk); #1; exp_start = 1'b0;
    @(negedge clk); bus.aip_start = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic done_pulse();
    @(negedge clk); core_done = 1'b1;
    @(posedge clk); #1; m_busy = 1'b0;
    $display("[TB] core_done pulse");
    @(negedge clk); core_done = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Interrupt output lags the flag/mask registers by one clock.
  always @(posedge clk or posedge rst) begin
    if (rst) exp_int = 1'b0;
    else     exp_int = |(m_flags & m_mask);
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("dataOut", bus.aip_dataOut, exp_dout);
      check("mem_in_we", mem_in_we, exp_we);
      if (exp_we) begin
        check("mem_in_addr", mem_in_addr, exp_waddr);
        check("mem_in_data", mem_in_data, exp_wdata);
      end
      check("mem_out_addr", mem_out_addr, 8'(m_ptr_out));
      check("conf_regs", conf_regs, m_conf_flat());
      check("core_start", core_start, exp_start);
      check("aip_int", bus.aip_int, exp_int);
    end
  end

  always @(negedge clk) begin
    if (mem_in_we === 1'b1) wlog.push_back('{mem_in_addr, mem_in_data});
    if (core_start === 1'b1) start_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 32'hF000_0000 + i;
    ram[0] = 32'd10; ram[1] = 32'd11; ram[2] = 32'd12;
    bus.aip_config = '0; bus.aip_dataIn = '0;
    bus.aip_read = 1'b0; bus.aip_write = 1'b0; bus.aip_start = 1'b0;
    model_reset();

    @(posedge clk); #1; chk_en = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_dout", bus.aip_dataOut, 32'h0);
    check("reset_conf", conf_regs, 256'h0);
    rst = 1'b0;

    // ID and unmapped reads
    hr(31); check("lit_id", bus.aip_dataOut, 32'h00001001);
    hr(7);  check("lit_cfg7", bus.aip_dataOut, 32'h0);

    // Input-memory burst and pointer wrap
    wlog.delete();
    hw(1, 32'd5);
    hw(0, 32'hAAAA_0001); hw(0, 32'hBBBB_0002); hw(0, 32'hCCCC_0003);
    hw(1, 32'd255);
    hw(0, 32'hDDDD_0004); hw(0, 32'hEEEE_0005);
    check("wlog_size", 32'(wlog.size()), 32'd5);
    check("w0_addr", wlog[0].a, 8'd5);   check("w0_data", wlog[0].d, 32'hAAAA_0001);
    check("w1_addr", wlog[1].a, 8'd6);   check("w2_addr", wlog[2].a, 8'd7);
    check("w2_data", wlog[2].d, 32'hCCCC_0003);
    check("w3_addr", wlog[3].a, 8'd255); check("w4_addr", wlog[4].a, 8'd0);
    check("w4_data", wlog[4].d, 32'hEEEE_0005);

    // Output-memory burst
    hw(3, 32'd0);
    hr(2); check("lit_rd0", bus.aip_dataOut, 32'd10);
    hr(2); check("lit_rd1", bus.aip_dataOut, 32'd11);
    hr(2); check("lit_rd2", bus.aip_dataOut, 32'd12);

    // Config registers
    hw(5, 32'd0);
    hw(4, 32'h1234_5678); hw(4, 32'h9ABC_DEF0);
    check("lit_conf0", conf_regs[31:0], 32'h1234_5678);
    check("lit_conf1", conf_regs[63:32], 32'h9ABC_DEF0);
    check("lit_conf_rest", conf_regs[255:64], 192'h0);

    // Interrupt flags, mask, W1C and set-wins collision
    hw(30, 32'h0001_0000);
    int_pulse(8'h01);
    hr(30); check("lit_stat_flag", bus.aip_dataOut, 32'h0001_0001);
    check("lit_int_on", bus.aip_int, 1'b1);
    hw(30, 32'h0001_0001);
    check("lit_int_off", bus.aip_int, 1'b0);
    hr(30); check("lit_stat_clr", bus.aip_dataOut, 32'h0001_0000);
    host_access(1'b0, 1'b1, 30, 32'h0001_0001, 8'h01);
    hr(30); check("lit_stat_setwins", bus.aip_dataOut, 32'h0001_0001);

    // Read/write collision: write happens, read data holds
    hr(31);
    wlog.delete();
    host_access(1'b1, 1'b1, 1, 32'd9, 8'h00);
    check("lit_collide_hold", bus.aip_dataOut, 32'h00001001);
    hw(0, 32'h0F0F_0F0F);
    check("lit_collide_wr", wlog[0].a, 8'd9);

    // Start/busy handshake
    done_pulse();
    hr(30); check("lit_idle_done", bus.aip_dataOut, 32'h0001_0001);
    host_start();
    check("lit_start_cnt1", 32'(start_cnt), 32'd1);
    hr(30); check("lit_busy", bus.aip_dataOut, 32'h0001_0101);
    host_start();
    check("lit_start_ignored", 32'(start_cnt), 32'd1);
    done_pulse();
    hr(30); check("lit_not_busy", bus.aip_dataOut, 32'h0001_0001);
    host_start();
    check("lit_start_cnt2", 32'(start_cnt), 32'd2);

    // Asynchronous reset while busy
    @(negedge clk); #2 rst = 1'b1; #1 model_reset();
    check("lit_rst_start", core_start, 1'b0);
    check("lit_rst_dout", bus.aip_dataOut, 32'h0);
    check("lit_rst_int", bus.aip_int, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    hr(30); check("lit_rst_status", bus.aip_dataOut, 32'h0);
    wlog.delete();
    hw(0, 32'h5555_AAAA);
    check("lit_rst_ptr", wlog[0].a, 8'd0);
    check("lit_rst_conf", conf_regs, 256'h0);

    repeat (3) @(negedge clk);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
